pwm_duty_meter: RTL

- Receive-side counterpart of the motor PWM generator: samples an external PWM line and measures high time and period in ticks; one tick = TICK_DIV clocks.
- Reports duty as 0..100 in the generator's 7-bit units, so a generator output looped back reads back its own Duty value.
- Used for motor-driver feedback, RC-receiver inputs and loopback self-test.
- Constant-high and constant-low inputs are reported through a timeout path.

---
 rtl/pwm_duty_meter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pwm_duty_meter.sv
// PWM receiver: measures high time and period in ticks, reports 7-bit duty; result 3 clocks after the rising edge
// (3+FILT_LEN with PWM_GLITCH_FILTER_EN), no backpressure: a publish while Valid is still set raises sticky Overrun.
module pwm_duty_meter #(
    parameter int TICK_DIV      = 1000,
    parameter int MAX_DUTY      = 100,
    parameter int TIMEOUT_TICKS = 200
`ifdef PWM_GLITCH_FILTER_EN
    ,
    parameter int FILT_LEN      = 4
`endif
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PwmIn,
    output logic [6:0] Duty,
    output logic [7:0] Period,
    output logic       Valid,
    input  logic       Ack,
    output logic       Overrun,
    output logic       Timeout
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [6:0] MAX_D7 = 7'(MAX_DUTY);
    localparam logic [7:0] MAX_D8 = 8'(MAX_DUTY);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t          state, state_nxt;
    logic            sync1, sync2, lvl, lvl_d;
    logic            rise, fall, edge_seen, tick;
    logic [PW-1:0]   presc, presc_cur;
    logic [7:0]      high_cnt, per_cnt;
    logic [SW-1:0]   since;
    logic            to_hit, pub_meas, pub_to, publish;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= PwmIn;
            sync2 <= sync1;
        end
    end

`ifdef PWM_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);
    logic          filt;
    logic [FW-1:0] fcnt;

    // Level follows the input only after FILT_LEN consecutive differing samples.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            filt <= 1'b0;
            fcnt <= '0;
        end else if (sync2 != filt) begin
            if (fcnt == FW'(FILT_LEN - 1)) begin
                filt <= sync2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end else begin
            fcnt <= '0;
        end
    end
    assign lvl = filt;
`else
    assign lvl = sync2;
`endif

    always_ff @(posedge Clock) begin
        if (!Reset) lvl_d <= 1'b0;
        else        lvl_d <= lvl;
    end

    assign rise      = lvl & ~lvl_d;
    assign fall      = ~lvl & lvl_d;
    assign edge_seen = rise | fall;

    // A rise restarts the prescaler phase, so ticks land TICK_DIV clocks apart from each rise.
    assign presc_cur = rise ? '0 : presc;
    assign tick      = !rise && (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge Clock) begin
        if (!Reset) presc <= '0;
        else        presc <= (presc_cur == PW'(TICK_DIV - 1)) ? '0 : presc_cur + 1'b1;
    end

    // Saturating at TIMEOUT_TICKS makes the timeout publish fire once per static episode.
    assign to_hit = tick && !edge_seen && (since == SW'(TIMEOUT_TICKS - 1));

    always_ff @(posedge Clock) begin
        if (!Reset)                                   since <= '0;
        else if (edge_seen)                           since <= '0;
        else if (tick && since != SW'(TIMEOUT_TICKS)) since <= since + 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pub_meas  = 1'b0;
        pub_to    = 1'b0;
        if (to_hit) begin
            pub_to    = 1'b1;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (rise) state_nxt = HIGH;
                HIGH: if (fall) state_nxt = LOW;
                LOW: begin
                    if (rise) begin
                        pub_meas  = 1'b1;
                        state_nxt = HIGH;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign publish = pub_meas | pub_to;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            high_cnt <= '0;
            per_cnt  <= '0;
        end else if (rise) begin
            high_cnt <= '0;
            per_cnt  <= '0;
        end else if (tick && state != IDLE) begin
            if (state == HIGH && high_cnt != 8'hFF) high_cnt <= high_cnt + 8'd1;
            if (per_cnt != 8'hFF)                   per_cnt  <= per_cnt + 8'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Duty    <= '0;
            Period  <= '0;
            Valid   <= 1'b0;
            Overrun <= 1'b0;
            Timeout <= 1'b0;
        end else begin
            if (pub_to) begin
                Duty   <= lvl ? MAX_D7 : 7'd0;
                Period <= 8'd0;
            end else if (pub_meas) begin
                Duty   <= (high_cnt > MAX_D8) ? MAX_D7 : high_cnt[6:0];
                Period <= per_cnt;
            end
            // A publish in the same cycle as Ack keeps Valid set.
            if (publish)  Valid <= 1'b1;
            else if (Ack) Valid <= 1'b0;
            if (publish && Valid && !Ack) Overrun <= 1'b1;
            if (pub_to)         Timeout <= 1'b1;
            else if (edge_seen) Timeout <= 1'b0;
        end
    end

endmodule
